flash_spi_reader: RTL and testbench
===================================

FLASH_SPI_READER -- requirements
Module: flash_spi_reader

Interface
REQ-001 SHALL have parameter ADDRESS_SIZE, default 24, flash byte-address width.
REQ-002 SHALL have parameter INIT_DELAY, default 16, clk cycles with CSB high before the wake command.
REQ-003 SHALL have parameter WAKE_DELAY, default 32, clk cycles with CSB high after the wake command (tRES1).
REQ-004 SHALL have ports, in order:
  clk  in  1  clock
  rst  in  1  reset: synchronous, active-high
  qspi_enable  in  1  controller enable
  qspi_changeAddress  in  1  start a new read at qspi_address
  qspi_address  in  ADDRESS_SIZE  byte start address
  qspi_requestData  in  1  consumer wants the next 32-bit word
  qspi_readData  out  32  last completed word
  qspi_readDataValid  out  1  one-cycle pulse, qspi_readData valid
  qspi_initialised  out  1  wake sequence complete
  qspi_busy  out  1  shift in progress, changeAddress not accepted
  flash_csb  out  1  chip select, active-low
  flash_sck  out  1  serial clock, SPI mode 0
  flash_mosi  out  1  serial data to flash
  flash_miso  in  1  serial data from flash

Function
REQ-005 SHALL run SCK at clk/2: one bit = 2 clk; MOSI updated with SCK low, MISO sampled on the clk where SCK rises.
REQ-006 SHALL send all command/address fields MSB first.
REQ-007 SHALL implement states INIT_WAIT, WAKE_CMD, WAKE_WAIT, IDLE, SEND_CMD, SEND_ADDR, READ_WORD, HOLD.
REQ-008 INIT_WAIT: entered from reset; counts INIT_DELAY cycles only while qspi_enable=1, CSB high; -> WAKE_CMD.
REQ-009 WAKE_CMD: CSB low, shift opcode 0xAB (16 clk); -> WAKE_WAIT with CSB high.
REQ-010 WAKE_WAIT: count WAKE_DELAY cycles; -> IDLE, qspi_initialised set and held until reset.
REQ-011 IDLE/HOLD: qspi_changeAddress accepted when qspi_enable && qspi_initialised && !qspi_busy; latches qspi_address, drives CSB high for exactly 2 clk, then -> SEND_CMD.
REQ-012 SEND_CMD: shift opcode 0x03 (16 clk); -> SEND_ADDR.
REQ-013 SEND_ADDR: shift the 24-bit latched address, zero-extended/truncated to 24 bits (48 clk); -> HOLD.
REQ-014 HOLD: CSB stays low, SCK low; if qspi_requestData=1 -> READ_WORD next clk.
REQ-015 READ_WORD: shift in 32 bits (64 clk); byte received first -> qspi_readData[7:0], last -> [31:24]; MSB-first within each byte.
REQ-016 qspi_readDataValid SHALL pulse for exactly 1 clk on the clk after the 32nd sample; qspi_readData updates the same clk and is held until the next word completes; FSM -> HOLD the same clk.
REQ-017 Consecutive words SHALL continue the same CS transaction (no re-address); a consumer holding qspi_requestData high gets a word every 65 clk.
REQ-018 qspi_busy = 1 in WAKE_CMD, SEND_CMD, SEND_ADDR, READ_WORD and the 2-clk CSB-high gap; 0 otherwise.
REQ-019 qspi_changeAddress while qspi_busy=1 or qspi_initialised=0 SHALL be ignored (no latch, no state change).
REQ-020 qspi_requestData deasserted mid-word SHALL NOT abort the word; the word completes and readDataValid still pulses.
REQ-021 qspi_enable falling in any post-init state SHALL force CSB high, SCK low, -> IDLE next clk; no readDataValid for the aborted word.
REQ-022 qspi_enable low during INIT_WAIT SHALL freeze the counter; low during WAKE_CMD/WAKE_WAIT SHALL not abort the wake sequence.
REQ-023 Bit and word counters SHALL not wrap within a field; the flash address auto-increments in the device, no internal address counter is kept.

Reset
REQ-024 On rst: state INIT_WAIT, counters 0, flash_csb=1, flash_sck=0, flash_mosi=0, qspi_readData=0, qspi_readDataValid=0, qspi_initialised=0, qspi_busy=0.
REQ-025 rst asserted mid-transaction SHALL take effect on the next clk edge regardless of SCK phase.

Structure
REQ-026 Opcodes (0xAB, 0x03), state encoding and CSB gap length SHALL live in a shared package flash_spi_pkg.
REQ-027 Bit-level shifting (SCK generation, MOSI shift-out, MISO shift-in, bit counter) SHALL be a sub-module flash_spi_shifter; the FSM lives in flash_spi_reader.

Verification
REQ-028 Reset, enable=1 -> CSB low exactly 16 clk later, MOSI carries 0xAB, CSB high, qspi_initialised=1 after 32 further clk.
REQ-029 changeAddress with address 0x000100, requestData=1, flash model returns bytes 11 22 33 44 -> MOSI 0x03,0x00,0x01,0x00; readDataValid pulse with readData=0x44332211.
REQ-030 requestData held 4 words -> 4 pulses 65 clk apart, CSB never rises, data matches consecutive model bytes.
REQ-031 changeAddress=0x0000F0 pulsed during SEND_ADDR of an earlier read -> ignored; original address completes.
REQ-032 enable dropped mid READ_WORD -> CSB high next clk, no readDataValid; re-enable plus changeAddress restarts cleanly without re-running the wake sequence.
REQ-033 rst asserted mid READ_WORD -> all outputs at REQ-024 values next clk, wake sequence repeats.

Source files
------------

// File: rtl/flash_spi_pkg.sv
// Shared definitions for the SPI flash reader: FSM states, flash opcodes and
// the chip-select gap that separates consecutive read transactions.
package flash_spi_pkg;

    typedef enum logic [2:0] {
        INIT_WAIT,
        WAKE_CMD,
        WAKE_WAIT,
        IDLE,
        SEND_CMD,
        SEND_ADDR,
        READ_WORD,
        HOLD
    } state_e;

    localparam logic [7:0] OP_WAKE      = 8'hAB;
    localparam logic [7:0] OP_READ      = 8'h03;
    localparam int         CSB_GAP      = 2;
    localparam int         GAP_W        = $clog2(CSB_GAP + 1);
    localparam int         FLASH_ADDR_W = 24;
    localparam int         SHIFT_W      = 32;

    // Flash streams the lowest-addressed byte first; it belongs in the low lane.
    function automatic logic [SHIFT_W-1:0] byte_swap32(input logic [SHIFT_W-1:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/flash_spi_shifter.sv
// SPI mode-0 bit engine: SCK at clk/2, MOSI shifted out MSB first while SCK is
// low, MISO captured on the clk where SCK rises.
module flash_spi_shifter
    import flash_spi_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               abort_i,
    input  logic               start_i,
    input  logic [5:0]         nbits_i,
    input  logic [SHIFT_W-1:0] data_i,
    input  logic               miso_i,
    output logic               sck_o,
    output logic               mosi_o,
    output logic               done_o,
    output logic [SHIFT_W-1:0] rx_data_o
);

    logic               active_q, active_d;
    logic               sck_q, sck_d;
    logic               mosi_q, mosi_d;
    logic [4:0]         bits_q, bits_d;
    logic [SHIFT_W-1:0] tx_q, tx_d;
    logic [SHIFT_W-1:0] rx_q, rx_d;

    always_comb begin
        active_d = active_q;
        sck_d    = sck_q;
        mosi_d   = mosi_q;
        bits_d   = bits_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        if (abort_i) begin
            active_d = 1'b0;
            sck_d    = 1'b0;
            mosi_d   = 1'b0;
            bits_d   = '0;
        end else if (start_i) begin
            // A new field may start on the same clk the previous one finishes.
            active_d = 1'b1;
            sck_d    = 1'b0;
            mosi_d   = data_i[SHIFT_W-1];
            tx_d     = {data_i[SHIFT_W-2:0], 1'b0};
            bits_d   = 5'(nbits_i - 6'd1);
        end else if (active_q) begin
            if (!sck_q) begin
                sck_d = 1'b1;
                rx_d  = {rx_q[SHIFT_W-2:0], miso_i};
            end else if (bits_q == '0) begin
                active_d = 1'b0;
                sck_d    = 1'b0;
                mosi_d   = 1'b0;
            end else begin
                sck_d  = 1'b0;
                mosi_d = tx_q[SHIFT_W-1];
                tx_d   = {tx_q[SHIFT_W-2:0], 1'b0};
                bits_d = bits_q - 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            sck_q    <= 1'b0;
            mosi_q   <= 1'b0;
            bits_q   <= '0;
        end else begin
            active_q <= active_d;
            sck_q    <= sck_d;
            mosi_q   <= mosi_d;
            bits_q   <= bits_d;
        end
    end

    always_ff @(posedge clk) begin
        tx_q <= tx_d;
        rx_q <= rx_d;
    end

    assign sck_o     = sck_q;
    assign mosi_o    = mosi_q;
    assign done_o    = active_q & sck_q & (bits_q == '0);
    assign rx_data_o = rx_q;

endmodule

// File: rtl/flash_spi_reader.sv
// Streaming SPI flash reader: wakes the device, then issues 0x03 reads and
// keeps the chip selected so successive 32-bit words stream on request.
module flash_spi_reader
    import flash_spi_pkg::*;
#(
    parameter int ADDRESS_SIZE = 24,
    parameter int INIT_DELAY   = 16,
    parameter int WAKE_DELAY   = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    qspi_enable,
    input  logic                    qspi_changeAddress,
    input  logic [ADDRESS_SIZE-1:0] qspi_address,
    input  logic                    qspi_requestData,
    output logic [31:0]             qspi_readData,
    output logic                    qspi_readDataValid,
    output logic                    qspi_initialised,
    output logic                    qspi_busy,
    output logic                    flash_csb,
    output logic                    flash_sck,
    output logic                    flash_mosi,
    input  logic                    flash_miso
);

    state_e                  state_q, state_d;
    logic [31:0]             dly_q, dly_d;
    logic                    gap_q, gap_d;
    logic [GAP_W-1:0]        gap_cnt_q, gap_cnt_d;
    logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    valid_q, valid_d;
    logic                    init_q, init_d;
    logic                    busy_q, busy_d;
    logic                    csb_q, csb_d;

    logic                    sh_start, sh_done;
    logic [5:0]              sh_nbits;
    logic [SHIFT_W-1:0]      sh_data, sh_rx;
    logic                    post_init, abort, accept;
    logic [FLASH_ADDR_W-1:0] addr24;

    if (ADDRESS_SIZE >= FLASH_ADDR_W) begin : g_addr_trunc
        assign addr24 = addr_q[FLASH_ADDR_W-1:0];
    end else begin : g_addr_ext
        assign addr24 = {{(FLASH_ADDR_W-ADDRESS_SIZE){1'b0}}, addr_q};
    end

    assign post_init = state_q inside {IDLE, SEND_CMD, SEND_ADDR, READ_WORD, HOLD};
    assign abort     = post_init && !qspi_enable;
    assign accept    = (state_q inside {IDLE, HOLD}) && qspi_enable && init_q
                       && !busy_q && qspi_changeAddress;

    always_comb begin
        state_d   = state_q;
        dly_d     = dly_q;
        gap_d     = gap_q;
        gap_cnt_d = gap_cnt_q;
        addr_d    = addr_q;
        rdata_d   = rdata_q;
        valid_d   = 1'b0;
        init_d    = init_q;
        sh_start  = 1'b0;
        sh_nbits  = 6'd0;
        sh_data   = '0;
        if (abort) begin
            state_d = IDLE;
            gap_d   = 1'b0;
        end else begin
            case (state_q)
                INIT_WAIT: begin
                    if (qspi_enable) begin
                        if (dly_q == 32'(INIT_DELAY - 1)) begin
                            state_d  = WAKE_CMD;
                            dly_d    = '0;
                            sh_start = 1'b1;
                            sh_nbits = 6'd8;
                            sh_data  = {OP_WAKE, 24'h0};
                        end else begin
                            dly_d = dly_q + 32'd1;
                        end
                    end
                end
                WAKE_CMD: if (sh_done) state_d = WAKE_WAIT;
                WAKE_WAIT: begin
                    if (dly_q == 32'(WAKE_DELAY - 1)) begin
                        state_d = IDLE;
                        dly_d   = '0;
                        init_d  = 1'b1;
                    end else begin
                        dly_d = dly_q + 32'd1;
                    end
                end
                IDLE, HOLD: begin
                    // Parking in IDLE during the gap keeps CSB high and ignores requestData.
                    if (accept) begin
                        addr_d    = qspi_address;
                        gap_d     = 1'b1;
                        gap_cnt_d = GAP_W'(CSB_GAP - 1);
                        state_d   = IDLE;
                    end else if (gap_q) begin
                        if (gap_cnt_q == '0) begin
                            gap_d    = 1'b0;
                            state_d  = SEND_CMD;
                            sh_start = 1'b1;
                            sh_nbits = 6'd8;
                            sh_data  = {OP_READ, 24'h0};
                        end else begin
                            gap_cnt_d = gap_cnt_q - GAP_W'(1);
                        end
                    end else if (state_q == HOLD && qspi_requestData) begin
                        state_d  = READ_WORD;
                        sh_start = 1'b1;
                        sh_nbits = 6'd32;
                    end
                end
                SEND_CMD: begin
                    if (sh_done) begin
                        state_d  = SEND_ADDR;
                        sh_start = 1'b1;
                        sh_nbits = 6'd24;
                        sh_data  = {addr24, 8'h0};
                    end
                end
                SEND_ADDR: if (sh_done) state_d = HOLD;
                READ_WORD: begin
                    if (sh_done) begin
                        state_d = HOLD;
                        rdata_d = byte_swap32(sh_rx);
                        valid_d = 1'b1;
                    end
                end
                default: state_d = INIT_WAIT;
            endcase
        end
        busy_d = (state_d inside {WAKE_CMD, SEND_CMD, SEND_ADDR, READ_WORD}) || gap_d;
        csb_d  = !(state_d inside {WAKE_CMD, SEND_CMD, SEND_ADDR, READ_WORD, HOLD});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= INIT_WAIT;
            dly_q     <= '0;
            gap_q     <= 1'b0;
            gap_cnt_q <= '0;
            rdata_q   <= '0;
            valid_q   <= 1'b0;
            init_q    <= 1'b0;
            busy_q    <= 1'b0;
            csb_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            dly_q     <= dly_d;
            gap_q     <= gap_d;
            gap_cnt_q <= gap_cnt_d;
            rdata_q   <= rdata_d;
            valid_q   <= valid_d;
            init_q    <= init_d;
            busy_q    <= busy_d;
            csb_q     <= csb_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
    end

    flash_spi_shifter u_shifter (
        .clk       (clk),
        .rst       (rst),
        .abort_i   (abort),
        .start_i   (sh_start),
        .nbits_i   (sh_nbits),
        .data_i    (sh_data),
        .miso_i    (flash_miso),
        .sck_o     (flash_sck),
        .mosi_o    (flash_mosi),
        .done_o    (sh_done),
        .rx_data_o (sh_rx)
    );

    assign qspi_readData      = rdata_q;
    assign qspi_readDataValid = valid_q;
    assign qspi_initialised   = init_q;
    assign qspi_busy          = busy_q;
    assign flash_csb          = csb_q;

endmodule

// File: tb/tb_flash_spi_reader.sv
// Directed bench for flash_spi_reader with a small behavioural SPI flash whose
// byte at address a is ((a - 0xFF) * 0x11) & 0xFF.
module tb_flash_spi_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        qspi_enable;
    logic        qspi_changeAddress;
    logic [23:0] qspi_address;
    logic        qspi_requestData;
    logic [31:0] qspi_readData;
    logic        qspi_readDataValid;
    logic        qspi_initialised;
    logic        qspi_busy;
    logic        flash_csb;
    logic        flash_sck;
    logic        flash_mosi;
    logic        flash_miso;

    always #5 clk = ~clk;

    flash_spi_reader #(
        .ADDRESS_SIZE (24),
        .INIT_DELAY   (16),
        .WAKE_DELAY   (32)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .qspi_enable        (qspi_enable),
        .qspi_changeAddress (qspi_changeAddress),
        .qspi_address       (qspi_address),
        .qspi_requestData   (qspi_requestData),
        .qspi_readData      (qspi_readData),
        .qspi_readDataValid (qspi_readDataValid),
        .qspi_initialised   (qspi_initialised),
        .qspi_busy          (qspi_busy),
        .flash_csb          (flash_csb),
        .flash_sck          (flash_sck),
        .flash_mosi         (flash_mosi),
        .flash_miso         (flash_miso)
    );

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;
    int csb_rises = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge flash_csb) csb_rises <= csb_rises + 1;

    // Behavioural flash
    logic        miso_r    = 1'b0;
    logic        csb_prev  = 1'b1;
    logic        sck_prev  = 1'b0;
    int          rx_cnt    = 0;
    int          tx_idx    = 0;
    int          last_cnt  = 0;
    logic [31:0] rx_sr     = '0;
    logic [31:0] last_rx   = '0;
    logic [31:0] cmd_word  = '0;
    logic [23:0] rd_addr   = '0;

    assign flash_miso = miso_r;

    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        logic [31:0] p;
        p = ({8'h0, a} - 32'h0FF) * 32'd17;
        return p[7:0];
    endfunction

    always @(negedge clk) begin
        logic [7:0] b;
        if (flash_csb) begin
            if (!csb_prev) begin
                last_cnt = rx_cnt;
                last_rx  = rx_sr;
            end
            rx_cnt = 0;
            rx_sr  = '0;
            tx_idx = 0;
        end else begin
            if (flash_sck && !sck_prev) begin
                rx_sr  = {rx_sr[30:0], flash_mosi};
                rx_cnt = rx_cnt + 1;
                if (rx_cnt == 32) begin
                    cmd_word = rx_sr;
                    rd_addr  = rx_sr[23:0];
                end
            end
            if (!flash_sck && sck_prev && rx_cnt >= 32) begin
                b      = mem_byte(rd_addr + 24'(tx_idx / 8));
                miso_r = b[7 - (tx_idx % 8)];
                tx_idx = tx_idx + 1;
            end
        end
        csb_prev = flash_csb;
        sck_prev = flash_sck;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic edges_until_csb(input logic lvl, input int budget, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (flash_csb !== lvl && n < budget);
    endtask

    task automatic wait_valid(input int budget, output int t, output logic [31:0] d, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        t  = 0;
        d  = '0;
        while (n < budget && !ok) begin
            @(negedge clk);
            n++;
            if (qspi_readDataValid === 1'b1) begin
                ok = 1'b1;
                t  = cyc;
                d  = qspi_readData;
            end
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_val({pfx, "_csb"},   32'(flash_csb),          32'd1);
        check_val({pfx, "_sck"},   32'(flash_sck),          32'd0);
        check_val({pfx, "_mosi"},  32'(flash_mosi),         32'd0);
        check_val({pfx, "_rdata"}, qspi_readData,           32'd0);
        check_val({pfx, "_valid"}, 32'(qspi_readDataValid), 32'd0);
        check_val({pfx, "_init"},  32'(qspi_initialised),   32'd0);
        check_val({pfx, "_busy"},  32'(qspi_busy),          32'd0);
    endtask

    // Issue changeAddress for one clk; returns the cyc value of the negedge it was driven on.
    task automatic start_read(input logic [23:0] a, output int c0);
        @(negedge clk);
        qspi_address       = a;
        qspi_changeAddress = 1'b1;
        qspi_requestData   = 1'b1;
        c0                 = cyc;
        @(negedge clk);
        qspi_changeAddress = 1'b0;
    endtask

    initial begin
        int          n, c0, t, t_prev, bad, rises0;
        logic [31:0] d;
        bit          ok;
        logic [31:0] exp_words [4];

        exp_words[0] = 32'h44332211;
        exp_words[1] = 32'h88776655;
        exp_words[2] = 32'hCCBBAA99;
        exp_words[3] = 32'h10FFEEDD;

        rst                = 1'b1;
        qspi_enable        = 1'b0;
        qspi_changeAddress = 1'b0;
        qspi_address       = '0;
        qspi_requestData   = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_outputs("rst");

        // Enable low: init counter frozen, CSB stays high
        rst = 1'b0;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (flash_csb !== 1'b1) bad++;
        end
        check_val("init_freeze_csb_low_cycles", bad, 0);

        // Wake sequence
        qspi_enable = 1'b1;
        edges_until_csb(1'b0, 200, n);
        check_val("wake_csb_low_delay", n, 16);
        edges_until_csb(1'b1, 200, n);
        check_val("wake_cmd_len", n, 16);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (qspi_initialised !== 1'b1 && n < 200);
        check_val("wake_wait_len", n, 32);
        @(negedge clk);
        #1;
        check_val("wake_bits", last_cnt, 8);
        check_val("wake_opcode", last_rx, 32'h000000AB);

        // Read at 0x000100, four streamed words
        start_read(24'h000100, c0);
        check_val("gap_busy", 32'(qspi_busy), 32'd1);
        wait_valid(400, t, d, ok);
        check_val("rd1_seen", 32'(ok), 32'd1);
        check_val("rd1_latency", t - (c0 + 1), 131);
        check_val("rd1_cmd_addr", cmd_word, 32'h03000100);
        check_val("rd1_word0", d, exp_words[0]);
        rises0 = csb_rises;
        @(negedge clk);
        check_val("valid_one_clk", 32'(qspi_readDataValid), 32'd0);
        for (int w = 1; w < 4; w++) begin
            t_prev = t;
            wait_valid(200, t, d, ok);
            if (w == 3) qspi_requestData = 1'b0;
            check_val($sformatf("stream_seen%0d", w), 32'(ok), 32'd1);
            check_val($sformatf("stream_interval%0d", w), t - t_prev, 65);
            check_val($sformatf("stream_word%0d", w), d, exp_words[w]);
        end
        check_val("stream_csb_rises", csb_rises - rises0, 0);

        // changeAddress during SEND_ADDR is ignored
        start_read(24'h000120, c0);
        repeat (30) @(negedge clk);
        qspi_address       = 24'h0000F0;
        qspi_changeAddress = 1'b1;
        @(negedge clk);
        qspi_changeAddress = 1'b0;
        check_val("busy_in_addr", 32'(qspi_busy), 32'd1);
        wait_valid(400, t, d, ok);
        qspi_requestData = 1'b0;
        check_val("ign_seen", 32'(ok), 32'd1);
        check_val("ign_latency", t - (c0 + 1), 131);
        check_val("ign_cmd_addr", cmd_word, 32'h03000120);
        check_val("ign_word", d, 32'h64534231);

        // Enable dropped mid word
        @(negedge clk);
        qspi_requestData = 1'b1;
        repeat (20) @(negedge clk);
        check_val("abort_pre_csb", 32'(flash_csb), 32'd0);
        qspi_enable      = 1'b0;
        qspi_requestData = 1'b0;
        @(posedge clk);
        #1;
        check_val("abort_csb", 32'(flash_csb), 32'd1);
        check_val("abort_sck", 32'(flash_sck), 32'd0);
        check_val("abort_busy", 32'(qspi_busy), 32'd0);
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (qspi_readDataValid === 1'b1) bad++;
        end
        check_val("abort_no_valid", bad, 0);
        check_val("abort_keeps_init", 32'(qspi_initialised), 32'd1);
        @(negedge clk);
        qspi_enable = 1'b1;
        start_read(24'h000100, c0);
        wait_valid(400, t, d, ok);
        qspi_requestData = 1'b0;
        check_val("restart_seen", 32'(ok), 32'd1);
        check_val("restart_latency", t - (c0 + 1), 131);
        check_val("restart_word", d, 32'h44332211);

        // Reset mid word
        @(negedge clk);
        qspi_requestData = 1'b1;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst              = 1'b0;
        qspi_requestData = 1'b0;
        edges_until_csb(1'b0, 200, n);
        check_val("rewake_csb_low_delay", n, 16);
        edges_until_csb(1'b1, 200, n);
        check_val("rewake_cmd_len", n, 16);
        @(negedge clk);
        #1;
        check_val("rewake_opcode", last_rx, 32'h000000AB);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
